// File: rtl/mem_stage_dm_pkg.sv
// Shared encodings for the memory stage and the W-stage load extender.
package mem_stage_dm_pkg;

  // Store op encodings (st_op_m)
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  // Load op encodings (ld_op_m); the W-stage extender decodes the same values
  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LH  = 3'b100;

  // Exception codes reported on exc_code_m
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

endpackage

// File: rtl/mem_stage_dm_byte_en_gen.sv
// Store lane steering: raw byte enables, replicated write data and the
// alignment check. A store op takes precedence over the load flag.
module dm_byte_en_gen
  import mem_stage_dm_pkg::*;
(
  input  logic [1:0]  st_op_i,
  input  logic [2:0]  ld_op_i,
  input  logic        is_load_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_raw_o,
  output logic [31:0] lane_o,
  output logic        misalign_o
);

  // Decode the access size into enables, lane data and misalignment
  always_comb begin
    be_raw_o   = 4'b0000;
    lane_o     = wdata_i;
    misalign_o = 1'b0;
    case (st_op_i)
      ST_SB: begin
        be_raw_o = 4'b0001 << addr_lo_i;
        lane_o   = {4{wdata_i[7:0]}};
      end
      ST_SH: begin
        be_raw_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        lane_o     = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      ST_SW: begin
        be_raw_o   = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      default: begin
        if (is_load_i) begin
          case (ld_op_i)
            LD_LW:          misalign_o = |addr_lo_i;
            LD_LHU, LD_LH:  misalign_o = addr_lo_i[0];
            default:        misalign_o = 1'b0;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_dm.sv
// Memory stage: word-organised data memory, address exceptions and the
// M/W pipeline register feeding the W-stage load extender.
module mem_stage_dm
  import mem_stage_dm_pkg::*;
#(
  parameter int WORD_AW = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic [1:0]  st_op_m,
  input  logic [2:0]  ld_op_m,
  input  logic        is_load_m,
  output logic [3:0]  be_m,
  output logic [4:0]  exc_code_m,
  output logic [31:0] rdata_w,
  output logic [1:0]  addr2_w,
  output logic [2:0]  ld_op_w,
  output logic        load_valid_w
);

  localparam int DEPTH = 1 << WORD_AW;

  logic [31:0]        mem_q [DEPTH];
  logic [WORD_AW-1:0] word_idx;
  logic               out_of_range;
  logic               is_store;
  logic               is_load_eff;
  logic [3:0]         be_raw;
  logic [31:0]        lane_data;
  logic               misalign;
  logic [31:0]        rd_word;

  logic [31:0] rdata_d, rdata_q;
  logic [1:0]  addr2_d, addr2_q;
  logic [2:0]  ld_op_d, ld_op_q;
  logic        lv_d, lv_q;

  assign word_idx     = addr_m[WORD_AW+1:2];
  assign out_of_range = |addr_m[31:WORD_AW+2];
  assign is_store     = (st_op_m != ST_NONE);
  // A decoder asserting both load and store is treated as a store
  assign is_load_eff  = is_load_m & ~is_store;

  dm_byte_en_gen u_be_gen (
    .st_op_i    (st_op_m),
    .ld_op_i    (ld_op_m),
    .is_load_i  (is_load_eff),
    .addr_lo_i  (addr_m[1:0]),
    .wdata_i    (wdata_m),
    .be_raw_o   (be_raw),
    .lane_o     (lane_data),
    .misalign_o (misalign)
  );

  // Address exception classification, independent of stall/flush
  always_comb begin
    exc_code_m = EXC_NONE;
    if (valid_m && is_store && (misalign || out_of_range)) begin
      exc_code_m = EXC_ADES;
    end else if (valid_m && is_load_eff && (misalign || out_of_range)) begin
      exc_code_m = EXC_ADEL;
    end
  end

  assign be_m = (valid_m && (exc_code_m == EXC_NONE) && !stall) ? be_raw : 4'b0000;

  // Data array: byte-lane writes, whole array cleared by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be_m[b]) begin
          mem_q[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

  // Asynchronous read returns the pre-write word
  assign rd_word = mem_q[word_idx];

  // M/W next state: flush beats stall; non-loads carry a zero data word
  always_comb begin
    rdata_d = rdata_q;
    addr2_d = addr2_q;
    ld_op_d = ld_op_q;
    lv_d    = lv_q;
    if (flush) begin
      rdata_d = '0;
      addr2_d = '0;
      ld_op_d = '0;
      lv_d    = 1'b0;
    end else if (!stall) begin
      lv_d    = valid_m & is_load_eff & (exc_code_m == EXC_NONE);
      rdata_d = lv_d ? rd_word : 32'h0;
      addr2_d = addr_m[1:0];
      ld_op_d = ld_op_m;
    end
  end

  // M/W pipeline register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      addr2_q <= '0;
      ld_op_q <= '0;
      lv_q    <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      addr2_q <= addr2_d;
      ld_op_q <= ld_op_d;
      lv_q    <= lv_d;
    end
  end

  assign rdata_w      = rdata_q;
  assign addr2_w      = addr2_q;
  assign ld_op_w      = ld_op_q;
  assign load_valid_w = lv_q;

endmodule

// File: tb/tb_mem_stage_dm.sv
// Bench for mem_stage_dm: table of accesses with hand-derived expectations,
// plus stall, flush and reset sequences.
module tb_mem_stage_dm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, flush, valid_m, is_load_m;
  logic [31:0] addr_m, wdata_m;
  logic [1:0]  st_op_m;
  logic [2:0]  ld_op_m;
  logic [3:0]  be_m;
  logic [4:0]  exc_code_m;
  logic [31:0] rdata_w;
  logic [1:0]  addr2_w;
  logic [2:0]  ld_op_w;
  logic        load_valid_w;

  int checks = 0;
  int failures = 0;

  mem_stage_dm #(.WORD_AW(10)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .valid_m(valid_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .st_op_m(st_op_m), .ld_op_m(ld_op_m), .is_load_m(is_load_m),
    .be_m(be_m), .exc_code_m(exc_code_m), .rdata_w(rdata_w),
    .addr2_w(addr2_w), .ld_op_w(ld_op_w), .load_valid_w(load_valid_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, stl, fl;
    logic [31:0] addr, wdata;
    logic [1:0]  st;
    logic [2:0]  ld;
    logic        isld;
    logic [3:0]  be;
    logic [4:0]  exc;
    logic [31:0] rd;
    logic [1:0]  a2;
    logic [2:0]  lo;
    logic        lv;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[15];

  function automatic vec_t mk(logic valid, logic stl, logic fl, logic [31:0] addr,
                              logic [31:0] wdata, logic [1:0] st, logic [2:0] ld,
                              logic isld, logic [3:0] be, logic [4:0] exc,
                              logic [31:0] rd, logic [1:0] a2, logic [2:0] lo, logic lv);
    vec_t v;
    v.valid = valid; v.stl = stl; v.fl = fl; v.addr = addr; v.wdata = wdata;
    v.st = st; v.ld = ld; v.isld = isld; v.be = be; v.exc = exc;
    v.rd = rd; v.a2 = a2; v.lo = lo; v.lv = lv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    valid_m = 0; stall = 0; flush = 0; addr_m = 0; wdata_m = 0;
    st_op_m = 0; ld_op_m = 0; is_load_m = 0;
  endtask

  // Drive one M-stage cycle, check combinational outputs, then the W register
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    valid_m = v.valid; stall = v.stl; flush = v.fl; addr_m = v.addr;
    wdata_m = v.wdata; st_op_m = v.st; ld_op_m = v.ld; is_load_m = v.isld;
    #1;
    chk({tag, ".be_m"}, {28'h0, be_m}, {28'h0, v.be});
    chk({tag, ".exc_code_m"}, {27'h0, exc_code_m}, {27'h0, v.exc});
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".rdata_w"}, rdata_w, e.rd);
      chk({tag, ".addr2_w"}, {30'h0, addr2_w}, {30'h0, e.a2});
      chk({tag, ".ld_op_w"}, {29'h0, ld_op_w}, {29'h0, e.lo});
      chk({tag, ".load_valid_w"}, {31'h0, load_valid_w}, {31'h0, e.lv});
    end
  endtask

  task automatic chk_w_zero(input string tag);
    chk({tag, ".rdata_w"}, rdata_w, 32'h0);
    chk({tag, ".addr2_w"}, {30'h0, addr2_w}, 32'h0);
    chk({tag, ".ld_op_w"}, {29'h0, ld_op_w}, 32'h0);
    chk({tag, ".load_valid_w"}, {31'h0, load_valid_w}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        val stl fl addr          wdata         st     ld      isl be       exc rd            a2 lo      lv
    tbl[0]  = mk(1, 0, 0, 32'h20,   32'h12345678, 2'b11, 3'b000, 0, 4'b1111, 0, 32'h0,        0, 3'b000, 0);
    tbl[1]  = mk(1, 0, 0, 32'h21,   32'h000000AB, 2'b01, 3'b000, 0, 4'b0010, 0, 32'h0,        1, 3'b000, 0);
    tbl[2]  = mk(1, 0, 0, 32'h20,   32'h0,        2'b00, 3'b000, 1, 4'b0000, 0, 32'h1234AB78, 0, 3'b000, 1);
    tbl[3]  = mk(1, 0, 0, 32'h32,   32'h0000BEEF, 2'b10, 3'b000, 0, 4'b1100, 0, 32'h0,        2, 3'b000, 0);
    tbl[4]  = mk(1, 0, 0, 32'h32,   32'h0,        2'b00, 3'b100, 1, 4'b0000, 0, 32'hBEEF0000, 2, 3'b100, 1);
    tbl[5]  = mk(1, 0, 0, 32'h23,   32'hDEADBEEF, 2'b11, 3'b000, 0, 4'b0000, 5, 32'h0,        3, 3'b000, 0);
    tbl[6]  = mk(1, 0, 0, 32'h20,   32'h0,        2'b00, 3'b000, 1, 4'b0000, 0, 32'h1234AB78, 0, 3'b000, 1);
    tbl[7]  = mk(1, 0, 0, 32'h21,   32'h0,        2'b00, 3'b100, 1, 4'b0000, 4, 32'h0,        1, 3'b100, 0);
    tbl[8]  = mk(1, 0, 0, 32'h1000, 32'h0,        2'b00, 3'b000, 1, 4'b0000, 4, 32'h0,        0, 3'b000, 0);
    tbl[9]  = mk(1, 0, 0, 32'h1003, 32'h11,       2'b01, 3'b000, 0, 4'b0000, 5, 32'h0,        3, 3'b000, 0);
    tbl[10] = mk(1, 0, 0, 32'h23,   32'h0,        2'b00, 3'b001, 1, 4'b0000, 0, 32'h1234AB78, 3, 3'b001, 1);
    tbl[11] = mk(0, 0, 0, 32'h23,   32'h99999999, 2'b11, 3'b000, 0, 4'b0000, 0, 32'h0,        3, 3'b000, 0);
    tbl[12] = mk(1, 0, 0, 32'h45,   32'h55AA55AA, 2'b11, 3'b000, 1, 4'b0000, 5, 32'h0,        1, 3'b000, 0);
    tbl[13] = mk(1, 0, 0, 32'h22,   32'h0,        2'b00, 3'b011, 1, 4'b0000, 0, 32'h1234AB78, 2, 3'b011, 1);
    tbl[14] = mk(1, 0, 0, 32'h33,   32'h0,        2'b00, 3'b010, 1, 4'b0000, 0, 32'hBEEF0000, 3, 3'b010, 1);

    idle_inputs();
    reset_n = 1'b0;
    #12;
    chk_w_zero("por");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Stall for three cycles with a sw pending: no write, W register frozen
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 1, 0, 32'h40, 32'hCAFEF00D, 2'b11, 3'b000, 0, 4'b0000, 0,
              32'hBEEF0000, 3, 3'b010, 1), $sformatf("stall%0d", i));
    end
    step(mk(1, 0, 0, 32'h40, 32'hCAFEF00D, 2'b11, 3'b000, 0, 4'b1111, 0,
            32'h0, 0, 3'b000, 0), "stall_release");
    step(mk(1, 0, 0, 32'h40, 32'h0, 2'b00, 3'b000, 1, 4'b0000, 0,
            32'hCAFEF00D, 0, 3'b000, 1), "stall_readback");

    // Flush together with stall on a valid lw: bubble wins
    step(mk(1, 1, 1, 32'h40, 32'h0, 2'b00, 3'b000, 1, 4'b0000, 0,
            32'h0, 0, 3'b000, 0), "flush_stall");
    step(mk(1, 0, 0, 32'h42, 32'h0, 2'b00, 3'b011, 1, 4'b0000, 0,
            32'hCAFEF00D, 2, 3'b011, 1), "post_flush");

    // Reset mid-run with a store in flight: outputs clear at once, store lost
    @(negedge clk);
    valid_m = 1; addr_m = 32'h50; wdata_m = 32'h11111111; st_op_m = 2'b11;
    ld_op_m = 0; is_load_m = 0; stall = 0; flush = 0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_w_zero("async_reset");
    @(posedge clk);
    #1;
    chk_w_zero("reset_held");
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    step(mk(1, 0, 0, 32'h10, 32'h0, 2'b00, 3'b000, 1, 4'b0000, 0,
            32'h0, 0, 3'b000, 1), "rst_lw10");
    step(mk(1, 0, 0, 32'h50, 32'h0, 2'b00, 3'b000, 1, 4'b0000, 0,
            32'h0, 0, 3'b000, 1), "rst_lw50");
    step(mk(1, 0, 0, 32'h40, 32'h0, 2'b00, 3'b000, 1, 4'b0000, 0,
            32'h0, 0, 3'b000, 1), "rst_lw40");
    step(mk(1, 0, 0, 32'h20, 32'h0, 2'b00, 3'b000, 1, 4'b0000, 0,
            32'h0, 0, 3'b000, 1), "rst_lw20");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
